// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - game state encoding shared by the tick controller, display timer and top level
package game_timer_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_FINISHED = 2'd3
    } game_state_e;

endpackage

// File: rtl/game_tick_controller_if.sv
// rtl/game_tick_controller_if.sv - button, finish and tick/clear/status signals around the game tick controller
interface game_tick_controller_if;

    logic start_btn;
    logic pause_btn;
    logic game_finished;
    logic one_second_pulse;
    logic timer_clear;
    logic running;
    logic paused;
    logic finished;

    modport master (
        output start_btn, pause_btn, game_finished,
        input  one_second_pulse, timer_clear, running, paused, finished
    );

    modport slave (
        input  start_btn, pause_btn, game_finished,
        output one_second_pulse, timer_clear, running, paused, finished
    );

endinterface

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - button synchroniser and rising-edge strobe; debouncer under GAME_TICK_DEBOUNCE_EN
module btn_sync_edge #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    if (DEBOUNCE_CYCLES < 1) begin : g_db_check
        $error("btn_sync_edge: DEBOUNCE_CYCLES must be >= 1");
    end

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
        end
    end

`ifdef GAME_TICK_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] db_cnt;
    logic          db_level;

    // Level follows the input only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync_q2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            db_level <= sync_q2;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync_q2;
`endif

    // Registered strobe so the FSM sees the event on the third edge after first sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            evt     <= 1'b0;
        end else begin
            level_q <= level;
            evt     <= level & ~level_q;
        end
    end

endmodule

// File: rtl/game_tick_controller.sv
// rtl/game_tick_controller.sv - game run/pause/finish FSM and one-second tick prescaler (GAME_TICK_DEBOUNCE_EN adds button debounce)
module game_tick_controller
    import game_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    game_tick_controller_if.slave  bus
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("game_tick_controller: CLK_FREQ_HZ/TICK_HZ must be >= 2");
    end

    logic start_evt;
    logic pause_evt;

    btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
        .clk (clk),
        .rst (rst),
        .btn (bus.start_btn),
        .evt (start_evt)
    );

    btn_sync_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
        .clk (clk),
        .rst (rst),
        .btn (bus.pause_btn),
        .evt (pause_evt)
    );

    game_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          clear_q, clear_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (start_evt) begin
                    state_d = ST_RUNNING;
                    clear_d = 1'b1;
                end
            end
            ST_RUNNING: begin
                if (bus.game_finished) begin
                    state_d = ST_FINISHED;
                    presc_d = '0;
                end else if (start_evt) begin
                    presc_d = '0;
                    clear_d = 1'b1;
                end else begin
                    // A tick on the pause edge still goes out; the pause then holds a zero prescaler.
                    if (presc_q == PW'(DIV - 1)) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    if (pause_evt) begin
                        state_d = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (start_evt) begin
                    state_d = ST_RUNNING;
                    presc_d = '0;
                    clear_d = 1'b1;
                end else if (pause_evt) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_FINISHED: begin
                presc_d = '0;
                if (start_evt) begin
                    state_d = ST_RUNNING;
                    clear_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
    end

    assign bus.one_second_pulse = tick_q;
    assign bus.timer_clear      = clear_q;
    assign bus.running          = (state_q == ST_RUNNING);
    assign bus.paused           = (state_q == ST_PAUSED);
    assign bus.finished         = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_game_tick_controller.sv
// tb/tb_game_tick_controller.sv - self-checking bench for game_tick_controller, with or without GAME_TICK_DEBOUNCE_EN
module tb_game_tick_controller;

    localparam int CLK_FREQ_HZ     = 100;
    localparam int TICK_HZ         = 10;
    localparam int DIV             = CLK_FREQ_HZ / TICK_HZ;
    localparam int DEBOUNCE_CYCLES = 8;
`ifdef GAME_TICK_DEBOUNCE_EN
    localparam int DB = DEBOUNCE_CYCLES;
`else
    localparam int DB = 0;
`endif
    localparam int PRESS = DB + 2;
    localparam int HN    = 16384;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   clear_total = 0;
    bit   last_tick = 1'b0;

    game_tick_controller_if gif();

    game_tick_controller #(
        .CLK_FREQ_HZ     (CLK_FREQ_HZ),
        .TICK_HZ         (TICK_HZ),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (gif)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-edge button history, filtered level and game rules in plain arithmetic.
    bit s_hist [2][HN];
    bit filt   [2][HN];
    int cyc = 0;
    int base = 0;
    int m_state = 0;
    int m_phase = 0;
    bit m_tick = 1'b0;
    bit m_clear = 1'b0;
    bit ev_start, ev_pause;

    function automatic bit samp(input int b, input int k);
        return (k > base) ? s_hist[b][k] : 1'b0;
    endfunction

    function automatic bit lvl(input int b, input int k);
        return (k > base) ? filt[b][k] : 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin : model_step
        bit flip;
        bit cur;
        if (rst) begin
            base    = cyc;
            m_state = 0;
            m_phase = 0;
            m_tick  = 1'b0;
            m_clear = 1'b0;
        end else begin
            cyc++;
            s_hist[0][cyc] = gif.start_btn;
            s_hist[1][cyc] = gif.pause_btn;
            for (int b = 0; b < 2; b++) begin
                if (DB == 0) begin
                    filt[b][cyc] = samp(b, cyc - 1);
                end else begin
                    cur  = lvl(b, cyc - 1);
                    flip = 1'b1;
                    for (int j = 0; j < DB; j++)
                        if (samp(b, cyc - 2 - j) == cur) flip = 1'b0;
                    filt[b][cyc] = flip ? ~cur : cur;
                end
            end
            ev_start = lvl(0, cyc - 2) & ~lvl(0, cyc - 3);
            ev_pause = lvl(1, cyc - 2) & ~lvl(1, cyc - 3);
            m_tick  = 1'b0;
            m_clear = 1'b0;
            if (m_state == 1 && gif.game_finished) begin
                m_state = 3;
                m_phase = 0;
            end else if (ev_start) begin
                m_state = 1;
                m_phase = 0;
                m_clear = 1'b1;
            end else if (m_state == 1) begin
                m_phase++;
                if (m_phase == DIV) begin
                    m_phase = 0;
                    m_tick  = 1'b1;
                end
                if (ev_pause) m_state = 2;
            end else if (m_state == 2 && ev_pause) begin
                m_state = 1;
            end
        end
    end

    function automatic logic [4:0] outs();
        return {gif.running, gif.paused, gif.finished, gif.one_second_pulse, gif.timer_clear};
    endfunction

    always @(negedge clk) begin
        check("outputs", 32'(outs()),
              32'({m_state == 1, m_state == 2, m_state == 3, m_tick, m_clear}));
        check("one_hot", 32'($countones({gif.running, gif.paused, gif.finished}) <= 1), 32'd1);
        check("tick_width", 32'(gif.one_second_pulse & last_tick), 32'd0);
        last_tick = gif.one_second_pulse;
        if (gif.timer_clear) clear_total++;
    end

    function automatic bit sig(input int which);
        case (which)
            0:       return gif.one_second_pulse;
            1:       return gif.timer_clear;
            2:       return gif.running;
            3:       return gif.paused;
            default: return gif.finished;
        endcase
    endfunction

    // Called at a negedge: drives the button(s) for len sampling edges.
    task automatic press(input bit st, input bit pa, input int len);
        if (st) gif.start_btn = 1'b1;
        if (pa) gif.pause_btn = 1'b1;
        repeat (len) @(negedge clk);
        if (st) gif.start_btn = 1'b0;
        if (pa) gif.pause_btn = 1'b0;
    endtask

    task automatic wait_sig(input int which, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(which) && n < budget);
        if (!sig(which)) n = -1;
    endtask

    task automatic count_sig(input int which, input int len, output int n);
        n = 0;
        repeat (len) begin
            @(negedge clk);
            n += int'(sig(which));
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int c0;
        bit pre;
        gif.start_btn     = 1'b0;
        gif.pause_btn     = 1'b0;
        gif.game_finished = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(outs()), 32'd0);
        rst = 1'b0;
        count_sig(0, 20, n);
        check("idle_no_tick", n, 0);

        // start, then three ticks DIV apart
        press(1'b1, 1'b0, PRESS);
        wait_sig(1, 40, n);
        check("t1_clear_latency", n, 2);
        check("t1_running", 32'(gif.running), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_sig(0, 3 * DIV, n);
            check("t1_tick_gap", n, DIV);
        end

        // pause 4 cycles after a tick, hold, resume
        repeat ((DIV - (DB % DIV)) % DIV) @(negedge clk);
        press(1'b0, 1'b1, PRESS);
        wait_sig(3, 40, n);
        check("t2_pause_latency", n, 2);
        count_sig(0, 50, n);
        check("t2_no_tick_paused", n, 0);
        press(1'b0, 1'b1, PRESS);
        wait_sig(2, 40, n);
        check("t2_resume_latency", n, 2);
        wait_sig(0, 3 * DIV, n);
        check("t2_resume_gap", n, DIV - 4);

        // finish, pause ignored, restart
        repeat (3) @(negedge clk);
        gif.game_finished = 1'b1;
        @(negedge clk);
        check("t3_finished", 32'(gif.finished), 32'd1);
        press(1'b0, 1'b1, PRESS);
        count_sig(0, 30, n);
        check("t3_no_tick_finished", n, 0);
        check("t3_still_finished", 32'(gif.finished), 32'd1);
        gif.game_finished = 1'b0;
        press(1'b1, 1'b0, PRESS);
        wait_sig(1, 40, n);
        check("t3_clear_latency", n, 2);
        wait_sig(0, 3 * DIV, n);
        check("t3_first_tick", n, DIV);

        // simultaneous start and pause while running
        repeat (2) @(negedge clk);
        press(1'b1, 1'b1, PRESS);
        wait_sig(1, 40, n);
        check("t4_clear_latency", n, 2);
        check("t4_state", 32'({gif.running, gif.paused}), 32'd2);

        // asynchronous reset between edges
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 pre = gif.running;
        check("t5_pre_running", 32'(pre), 32'd1);
        #1 rst = 1'b1;
        #1 check("t5_async_rst", 32'(outs()), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        count_sig(0, 40, n);
        check("t5_no_tick_idle", n, 0);
        check("t5_idle", 32'(outs()), 32'd0);

`ifdef GAME_TICK_DEBOUNCE_EN
        c0 = clear_total;
        press(1'b1, 1'b0, 3);
        repeat (40) @(negedge clk);
        check("t6_glitch_no_clear", clear_total - c0, 0);
        check("t6_glitch_idle", 32'(gif.running), 32'd0);
        c0 = clear_total;
        press(1'b1, 1'b0, 12);
        repeat (40) @(negedge clk);
        check("t6_one_restart", clear_total - c0, 1);
        check("t6_running", 32'(gif.running), 32'd1);
`else
        c0 = clear_total;
        press(1'b1, 1'b0, 1);
        repeat (10) @(negedge clk);
        check("t6_short_press_restart", clear_total - c0, 1);
`endif

        // randomized mix, every cycle checked against the model
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: repeat ($urandom_range(1, 25)) @(negedge clk);
                1: press(1'b1, 1'b0, int'($urandom_range(1, PRESS + 4)));
                2: press(1'b0, 1'b1, int'($urandom_range(1, PRESS + 4)));
                3: press(1'b1, 1'b1, int'($urandom_range(1, PRESS + 4)));
                4: begin
                    gif.game_finished = 1'b1;
                    repeat ($urandom_range(1, 4)) @(negedge clk);
                    gif.game_finished = 1'b0;
                end
                default: begin
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #($urandom_range(1, 4)) rst = 1'b1;
                        repeat (2) @(negedge clk);
                        rst = 1'b0;
                    end else begin
                        repeat (12) @(negedge clk);
                    end
                end
            endcase
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
